single_midi_in_rx: RTL and testbench
====================================

# single_midi_in_rx

Serial receiver for one MIDI input line: 31 250 baud, 8N1, LSB first, idle-high. It recovers each byte, flags MIDI status bytes (bit 7 set), and emits a one-cycle strobe per valid byte. It sits directly behind the MIDI input pin and feeds the MIDI message-assembly logic, which samples `data_rx`/`is_command` on or after the strobe.

## Interface
Parameters:
- `BYTE_W`, 8: data bits per frame.
- `MIDI_BAUD`, 31250: line bit rate.
- `MIDI_FRAME_SIZE`, 10: start + 8 data + stop. Informational; the frame format is fixed at 8N1.
- `SYSCLK_F`, 48000000: `sys_clk` frequency in Hz. `CLKS_PER_BIT = SYSCLK_F / MIDI_BAUD` (integer division; 1536 at defaults). `HALF_BIT = CLKS_PER_BIT / 2`.

Ports:
- `sys_clk`, in, 1: the single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `MIDI_IN`, in, 1: asynchronous serial line, idle high.
- `data_rx`, out, BYTE_W: last valid received byte.
- `is_command`, out, 1: bit 7 of `data_rx` (MIDI status byte).
- `new_byte_strobe`, out, 1: high for exactly one cycle per valid byte.

## Operation
- `MIDI_IN` passes through a 2-FF synchronizer. Both flops reset to 1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a synchronized high→low transition, clear the bit counter and go to START.
- START: after `HALF_BIT` cycles, sample the line.
  - Low: reload the counter and go to DATA with bit index 0.
  - High (glitch): return to IDLE with no output.
- DATA: every `CLKS_PER_BIT` cycles, sample the line into shift-register bit[index], LSB first. After bit 7, go to STOP.
- STOP: `CLKS_PER_BIT` cycles after the last data sample, sample the line.
  - High: in the next cycle, load `data_rx` with the shifted byte, set `is_command` to byte[7], and pulse `new_byte_strobe`. Then go to IDLE.
  - Low (framing error): go to IDLE. The byte is discarded. `data_rx`, `is_command` and the strobe are untouched.
- After a framing error, IDLE only detects a new falling edge. While the line stays low (break), nothing is received until the line returns high and falls again.
- `data_rx`/`is_command` hold their value until the next valid byte. Downstream may read them any number of cycles after the strobe.
- No running-status or message interpretation is done here.
- Reset values: `data_rx`=0, `is_command`=0, `new_byte_strobe`=0, FSM=IDLE, counters=0, synchronizer=1.
- Reset mid-frame aborts the frame silently. No strobe is produced for it.

## Timing
- Start edge on `MIDI_IN` → detection: 2–3 cycles (synchronizer plus edge register).
- Sample points, counted from detection: start bit at `HALF_BIT`; data bit k at `HALF_BIT + (k+1)*CLKS_PER_BIT`; stop bit at `HALF_BIT + 9*CLKS_PER_BIT`.
- Strobe: 1 cycle after the stop sample. `data_rx` is valid in the same cycle as the strobe.
- The FSM is back in IDLE at the strobe cycle. A new start edge arriving at the end of the stop bit (back-to-back frames) is detected with no lost cycles.
- Strobe width is exactly 1 cycle and never asserts on consecutive cycles.
- Baud tolerance is ±(`HALF_BIT` / (9.5·`CLKS_PER_BIT`)) ≈ ±5 %. No fractional-rate correction is applied.

## Structure
- The shared package holds the FSM state encoding and `CLKS_PER_BIT`/`HALF_BIT` derivation helpers. The MIDI status-bit index (7) may live there as a named constant.
- The 2-FF synchronizer is a natural sub-module, `sync_2ff`, with parameterized reset value 1.
- Counters are sized with `$clog2(CLKS_PER_BIT)`.

## Test plan
Use `SYSCLK_F` = 312500, giving `CLKS_PER_BIT` = 10, for fast simulation. Repeat one case at the defaults.
- Send 0x90 with a valid stop bit → one strobe; `data_rx`=0x90, `is_command`=1. Both hold until the next byte.
- Send 0x3C → `data_rx`=0x3C, `is_command`=0, single-cycle strobe at detection+`HALF_BIT`+90+1.
- Back-to-back 0x90, 0x3C, 0x7F with no idle gap → three strobes, values in order, none missed.
- Frame 0x45 with stop bit low → no strobe; `data_rx` keeps the previous value. A following valid 0x80 is received with `is_command`=1.
- Low glitch of 3 cycles (< `HALF_BIT`) → no strobe, FSM back in IDLE. The next valid frame is received correctly.
- Assert `rst` during data bit 4 → all outputs at reset values, no strobe for that frame. A frame sent after release is received correctly.

Source files
------------

// File: rtl/single_midi_in_rx_pkg.sv
// Shared definitions for the MIDI input receiver: FSM encoding and bit-timing helpers.
package single_midi_in_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Bit 7 marks a MIDI status (command) byte.
  localparam int STATUS_BIT = 7;

  function automatic int clks_per_bit(input int sysclk_f, input int baud);
    return sysclk_f / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 2;
  endfunction

endpackage

// File: rtl/single_midi_in_rx_sync.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/single_midi_in_rx.sv
// MIDI input receiver: 8N1 serial at MIDI_BAUD, LSB first, one-cycle strobe per valid byte.
module single_midi_in_rx
  import single_midi_in_rx_pkg::*;
#(
  parameter int BYTE_W          = 8,
  parameter int MIDI_BAUD       = 31250,
  parameter int MIDI_FRAME_SIZE = 10,
  parameter int SYSCLK_F        = 48000000
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              MIDI_IN,
  output logic [BYTE_W-1:0] data_rx,
  output logic              is_command,
  output logic              new_byte_strobe
);

  localparam int CLKS_PER_BIT = clks_per_bit(SYSCLK_F, MIDI_BAUD);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;
  // A frame never carries more data bits than the data register can hold.
  localparam int DATA_BITS    = (MIDI_FRAME_SIZE - 2 < BYTE_W) ? MIDI_FRAME_SIZE - 2 : BYTE_W;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic              w_rx;
  logic              r_rx_prev;
  rx_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [BYTE_W-1:0] r_shift;
  logic              r_frame_ok;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .i_clk(sys_clk),
    .i_rst(rst),
    .i_d  (MIDI_IN),
    .o_q  (w_rx)
  );

  // The byte is published one cycle after a good stop sample, while the FSM is already idle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_rx_prev       <= 1'b1;
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_idx           <= '0;
      r_shift         <= '0;
      r_frame_ok      <= 1'b0;
      data_rx         <= '0;
      is_command      <= 1'b0;
      new_byte_strobe <= 1'b0;
    end else begin
      r_rx_prev       <= w_rx;
      r_frame_ok      <= 1'b0;
      new_byte_strobe <= 1'b0;

      if (r_frame_ok) begin
        data_rx         <= r_shift;
        is_command      <= r_shift[STATUS_BIT];
        new_byte_strobe <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_rx_prev && !w_rx) begin
            r_cnt   <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            if (!w_rx) begin
              r_idx   <= '0;
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt      <= '0;
            r_frame_ok <= w_rx;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_single_midi_in_rx.sv
// Directed bench for single_midi_in_rx: a fast-rate instance (10 clocks/bit) and one at default rate.
module tb_single_midi_in_rx;

  localparam int CPB_FAST = 10;
  localparam int CPB_SLOW = 1536;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       midiFast = 1'b1;
  logic       midiSlow = 1'b1;
  logic [7:0] dataFast, dataSlow;
  logic       cmdFast, cmdSlow;
  logic       strobeFast, strobeSlow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] rxQ[$];
  int         strobeCycQ[$];
  int         consecFast = 0;
  logic       prevStrobeFast = 1'b0;
  int         slowCount = 0;
  int         slowStrobeCyc = 0;

  single_midi_in_rx #(.SYSCLK_F(312500)) dutFast (
    .sys_clk(clk), .rst(rst), .MIDI_IN(midiFast),
    .data_rx(dataFast), .is_command(cmdFast), .new_byte_strobe(strobeFast)
  );

  single_midi_in_rx dutSlow (
    .sys_clk(clk), .rst(rst), .MIDI_IN(midiSlow),
    .data_rx(dataSlow), .is_command(cmdSlow), .new_byte_strobe(strobeSlow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe with the byte visible in that same cycle.
  always @(negedge clk) begin
    if (strobeFast) begin
      rxQ.push_back({cmdFast, dataFast});
      strobeCycQ.push_back(cyc);
      if (prevStrobeFast) consecFast++;
    end
    prevStrobeFast = strobeFast;
    if (strobeSlow) begin
      slowCount++;
      slowStrobeCyc = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called aligned to posedge+1; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stopBit, input int cpb,
                            input bit slow, output int startCyc);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    startCyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (slow) midiSlow = frame[i];
      else midiFast = frame[i];
      wait_cycles(cpb);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(4);
    @(negedge clk);
    checks++; if (dataFast !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", dataFast); end
    checks++; if (cmdFast !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd: got %b expected 0", cmdFast); end
    checks++; if (strobeFast !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe: got %b expected 0", strobeFast); end
    checks++; if (dataSlow !== 8'h00 || strobeSlow !== 1'b0) begin failures++; $display("[TB] FAIL reset_slow: got data %h strobe %b expected 00/0", dataSlow, strobeSlow); end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_command_byte;
    int s;
    rxQ.delete(); strobeCycQ.delete();
    send_frame(8'h90, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 1) begin failures++; $display("[TB] FAIL cmd_count: got %0d expected 1", rxQ.size()); end
    if (rxQ.size() >= 1) begin
      checks++; if (rxQ[0] !== 9'h190) begin failures++; $display("[TB] FAIL cmd_value: got %h expected 190", rxQ[0]); end
    end
    wait_cycles(50);
    @(negedge clk);
    checks++; if (dataFast !== 8'h90 || cmdFast !== 1'b1) begin failures++; $display("[TB] FAIL cmd_hold: got %h/%b expected 90/1", dataFast, cmdFast); end
    @(posedge clk); #1;
  endtask

  task automatic test_data_byte;
    int s;
    rxQ.delete(); strobeCycQ.delete();
    send_frame(8'h3C, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 1) begin failures++; $display("[TB] FAIL data_count: got %0d expected 1", rxQ.size()); end
    if (rxQ.size() >= 1) begin
      checks++; if (rxQ[0] !== 9'h03C) begin failures++; $display("[TB] FAIL data_value: got %h expected 03C", rxQ[0]); end
      checks++; if (strobeCycQ[0] != s + 99) begin failures++; $display("[TB] FAIL data_timing: got cycle %0d expected %0d", strobeCycQ[0], s + 99); end
    end
  endtask

  task automatic test_back_to_back;
    int s;
    logic [8:0] expv[3];
    expv[0] = 9'h190; expv[1] = 9'h03C; expv[2] = 9'h07F;
    rxQ.delete(); strobeCycQ.delete();
    send_frame(8'h90, 1'b1, CPB_FAST, 1'b0, s);
    send_frame(8'h3C, 1'b1, CPB_FAST, 1'b0, s);
    send_frame(8'h7F, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 3) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 3", rxQ.size()); end
    for (int i = 0; i < 3; i++) begin
      if (rxQ.size() > i) begin
        checks++; if (rxQ[i] !== expv[i]) begin failures++; $display("[TB] FAIL b2b_value%0d: got %h expected %h", i, rxQ[i], expv[i]); end
      end
    end
    checks++; if (consecFast != 0) begin failures++; $display("[TB] FAIL strobe_width: got %0d consecutive strobes expected 0", consecFast); end
  endtask

  task automatic test_framing_error;
    int s;
    rxQ.delete(); strobeCycQ.delete();
    send_frame(8'h45, 1'b0, CPB_FAST, 1'b0, s);
    midiFast = 1'b1;
    wait_cycles(30);
    checks++; if (rxQ.size() != 0) begin failures++; $display("[TB] FAIL frame_err_strobe: got %0d strobes expected 0", rxQ.size()); end
    @(negedge clk);
    checks++; if (dataFast !== 8'h7F || cmdFast !== 1'b0) begin failures++; $display("[TB] FAIL frame_err_hold: got %h/%b expected 7F/0", dataFast, cmdFast); end
    @(posedge clk); #1;
    send_frame(8'h80, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 1 || (rxQ.size() == 1 && rxQ[0] !== 9'h180)) begin failures++; $display("[TB] FAIL frame_err_next: got %0d strobes last %h expected 1 of 180", rxQ.size(), (rxQ.size() > 0) ? rxQ[rxQ.size()-1] : 9'h0); end
  endtask

  task automatic test_glitch;
    int s;
    rxQ.delete(); strobeCycQ.delete();
    midiFast = 1'b0;
    wait_cycles(3);
    midiFast = 1'b1;
    wait_cycles(30);
    checks++; if (rxQ.size() != 0) begin failures++; $display("[TB] FAIL glitch_strobe: got %0d strobes expected 0", rxQ.size()); end
    send_frame(8'h55, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 1 || (rxQ.size() == 1 && rxQ[0] !== 9'h055)) begin failures++; $display("[TB] FAIL glitch_next: got %0d strobes last %h expected 1 of 055", rxQ.size(), (rxQ.size() > 0) ? rxQ[rxQ.size()-1] : 9'h0); end
  endtask

  task automatic test_reset_mid_frame;
    int s;
    rxQ.delete(); strobeCycQ.delete();
    // 0xF0 keeps the line high from bit 4 onward, so no false start follows reset release.
    fork
      send_frame(8'hF0, 1'b1, CPB_FAST, 1'b0, s);
      begin
        wait_cycles(55);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (dataFast !== 8'h00 || cmdFast !== 1'b0 || strobeFast !== 1'b0) begin failures++; $display("[TB] FAIL midreset_outputs: got %h/%b/%b expected 00/0/0", dataFast, cmdFast, strobeFast); end
        @(posedge clk); #1;
        rst = 1'b0;
      end
    join
    wait_cycles(20);
    checks++; if (rxQ.size() != 0) begin failures++; $display("[TB] FAIL midreset_strobe: got %0d strobes expected 0", rxQ.size()); end
    send_frame(8'hA7, 1'b1, CPB_FAST, 1'b0, s);
    wait_cycles(20);
    checks++; if (rxQ.size() != 1 || (rxQ.size() == 1 && rxQ[0] !== 9'h1A7)) begin failures++; $display("[TB] FAIL midreset_next: got %0d strobes last %h expected 1 of 1A7", rxQ.size(), (rxQ.size() > 0) ? rxQ[rxQ.size()-1] : 9'h0); end
  endtask

  task automatic test_default_rate;
    int s;
    slowCount = 0;
    send_frame(8'h90, 1'b1, CPB_SLOW, 1'b1, s);
    wait_cycles(2000);
    checks++; if (slowCount != 1) begin failures++; $display("[TB] FAIL slow_count: got %0d expected 1", slowCount); end
    checks++; if (slowStrobeCyc != s + 3 + 768 + 9 * CPB_SLOW + 1) begin failures++; $display("[TB] FAIL slow_timing: got cycle %0d expected %0d", slowStrobeCyc, s + 3 + 768 + 9 * CPB_SLOW + 1); end
    @(negedge clk);
    checks++; if (dataSlow !== 8'h90 || cmdSlow !== 1'b1) begin failures++; $display("[TB] FAIL slow_value: got %h/%b expected 90/1", dataSlow, cmdSlow); end
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_command_byte();
    test_data_byte();
    test_back_to_back();
    test_framing_error();
    test_glitch();
    test_reset_mid_frame();
    test_default_rate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
